alu_exec: RTL and testbench



---
 rtl/alu_pkg.sv | 19 +
 rtl/mult_seq.sv | 56 +++++
 rtl/alu_exec.sv | 125 ++++++++++++
 tb/tb_alu_exec.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU code table and execution FSM states, used by both the control
// decoder and the execution unit so the two ends agree on one encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ADDI = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_MULT = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/mult_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock,
// WIDTH clocks per product. done marks the final iteration; prod is valid then.
module mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // acc = {carry, upper half, multiplier-being-consumed}
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   upper_sum;
  logic [CW-1:0]    cnt;

  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? mcand : '0)};
    acc_nxt   = {1'b0, upper_sum, acc[WIDTH-1:1]};
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign prod = acc_nxt[2*WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  // Datapath registers carry no reset; busy qualifies them.
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      acc   <= {{(WIDTH+1){1'b0}}, b};
      mcand <= a;
    end else if (busy) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// EX-stage ALU: single-cycle ops complete in one clock, mult runs on the
// sequential multiplier while busy stalls the pipeline.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  alu_state_t state;

  logic signed [WIDTH-1:0] sa, sb, sum_s, diff_s;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf, alu_ill;
  logic                    mul_go, m_done;
  logic [2*WIDTH-1:0]      m_prod;

  assign sa     = signed'(a);
  assign sb     = signed'(b);
  assign sum_s  = sa + sb;
  assign diff_s = sa - sb;
  assign mul_go = (state == IDLE) && start && (alu_ctrl == ALU_MULT);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      ALU_ADD, ALU_ADDI: begin
        alu_res = unsigned'(sum_s);
        alu_ovf = add_ovf(sa, sb, sum_s);
      end
      ALU_SUB: begin
        alu_res = unsigned'(diff_s);
        alu_ovf = sub_ovf(sa, sb, diff_s);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_SLL:  alu_res = a << b[SHW-1:0];
      ALU_SRL:  alu_res = a >> b[SHW-1:0];
      ALU_MULT: alu_res = '0;
      default:  alu_ill = 1'b1;
    endcase
  end

  mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clk   (clk),
    .reset (reset),
    .start (mul_go),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (m_done),
    .prod  (m_prod)
  );

  // Outputs hold between completions; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      hi      <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (alu_ctrl == ALU_MULT) begin
              state <= MUL;
            end else begin
              result  <= alu_res;
              zero    <= (alu_res == '0);
              ovf     <= alu_ovf;
              illegal <= alu_ill;
              done    <= 1'b1;
            end
          end
        end
        MUL: begin
          if (m_done) begin
            result  <= m_prod[WIDTH-1:0];
            hi      <= m_prod[2*WIDTH-1:WIDTH];
            zero    <= (m_prod[WIDTH-1:0] == '0);
            ovf     <= 1'b0;
            illegal <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed cases plus random ops against an
// arithmetic reference model of the instruction semantics.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int     W    = 16;
  localparam longint MOD  = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);

  logic          clk = 1'b0;
  logic          reset, start;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  a, b;
  logic [W-1:0]  result, hi;
  logic          zero, ovf, illegal, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // model-held output state
  longint e_res, e_hi;
  bit     e_zero, e_ovf, e_ill;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .result(result), .hi(hi), .zero(zero), .ovf(ovf),
    .illegal(illegal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not reach its end, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint to_signed(input longint v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  // Instruction semantics in plain integer arithmetic.
  task automatic model(input logic [3:0] c, input longint av, input longint bv);
    longint s, p;
    e_ovf = 0;
    e_ill = 0;
    case (c)
      ALU_ADD, ALU_ADDI: begin
        s = to_signed(av) + to_signed(bv);
        e_ovf = (s >= HALF) || (s < -HALF);
        e_res = (av + bv) % MOD;
      end
      ALU_SUB: begin
        s = to_signed(av) - to_signed(bv);
        e_ovf = (s >= HALF) || (s < -HALF);
        e_res = (av - bv + MOD) % MOD;
      end
      ALU_AND:  e_res = av & bv;
      ALU_OR:   e_res = av | bv;
      ALU_SLL:  e_res = (av << (bv % W)) % MOD;
      ALU_SRL:  e_res = av >> (bv % W);
      ALU_MULT: begin
        p = av * bv;
        e_res = p % MOD;
        e_hi  = p / MOD;
      end
      default: begin
        e_res = 0;
        e_ill = 1;
      end
    endcase
    e_zero = (e_res == 0);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_done"},    done,    1);
    chk({tag, "_result"},  result,  e_res[31:0]);
    chk({tag, "_hi"},      hi,      e_hi[31:0]);
    chk({tag, "_zero"},    zero,    e_zero);
    chk({tag, "_ovf"},     ovf,     e_ovf);
    chk({tag, "_illegal"}, illegal, e_ill);
  endtask

  // Issue one op from a sample point (#1 after posedge); returns at the
  // sample point where done is expected. inject>=0 raises start mid-mult.
  task automatic run_op(input string tag, input logic [3:0] c,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int inject);
    int  n;
    bit  early_done;
    alu_ctrl = c; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (c == ALU_MULT) begin
      n = 0;
      early_done = 0;
      while (busy && n < 100) begin
        if (done) early_done = 1;
        if (n == inject) begin
          start = 1'b1; alu_ctrl = ALU_ADD;
          a = W'($urandom); b = W'($urandom);
        end else if (inject >= 0 && n == inject + 1) begin
          start = 1'b0;
          chk({tag, "_hold_result"}, result, e_res[31:0]);
          chk({tag, "_hold_hi"}, hi, e_hi[31:0]);
        end
        n++;
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk({tag, "_busy_cycles"}, n, W);
      chk({tag, "_no_early_done"}, early_done, 0);
    end
    model(c, longint'(av), longint'(bv));
    check_outs(tag);
  endtask

  logic [3:0] legal [8] = '{ALU_ADD, ALU_ADDI, ALU_SUB, ALU_AND,
                            ALU_OR, ALU_SLL, ALU_SRL, ALU_MULT};

  initial begin
    logic [3:0] c;
    reset = 1'b1; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
    e_res = 0; e_hi = 0; e_zero = 0; e_ovf = 0; e_ill = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf", ALU_ADD, 16'h7FFF, 16'h0001, -1);
    chk("add_ovf_const", result, 16'h8000);
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);
    chk("hold_after_done", result, 16'h8000);

    run_op("sub_zero", ALU_SUB, 16'h0005, 16'h0005, -1);
    run_op("sub_ovf", ALU_SUB, 16'h8000, 16'h0001, -1);
    chk("sub_ovf_const", result, 16'h7FFF);
    run_op("sll", ALU_SLL, 16'h0001, 16'h0013, -1);
    chk("sll_const", result, 16'h0008);
    run_op("srl", ALU_SRL, 16'h8000, 16'h000F, -1);
    chk("srl_const", result, 16'h0001);

    run_op("mult", ALU_MULT, 16'h1234, 16'h0100, 5);
    chk("mult_hi_const", hi, 16'h0012);
    chk("mult_lo_const", result, 16'h3400);
    @(posedge clk); #1;
    chk("mult_done_pulse", done, 0);

    // back-to-back single-cycle ops
    alu_ctrl = ALU_AND; a = 16'h0F0F; b = 16'h00FF; start = 1'b1;
    @(posedge clk); #1;
    model(ALU_AND, 64'h0F0F, 64'h00FF);
    check_outs("b2b_and");
    alu_ctrl = ALU_OR; a = 16'h1200; b = 16'h0034;
    @(posedge clk); #1;
    model(ALU_OR, 64'h1200, 64'h0034);
    check_outs("b2b_or");
    alu_ctrl = ALU_ADDI; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    model(ALU_ADDI, 64'h1111, 64'h2222);
    check_outs("b2b_addi");
    @(posedge clk); #1;
    chk("b2b_done_end", done, 0);

    run_op("illegal", 4'b1111, 16'hABCD, 16'h1234, -1);

    // reset 5 cycles into a mult
    alu_ctrl = ALU_MULT; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_hi", hi, 0);
    chk("abort_flags", {zero, ovf, illegal}, 0);
    e_res = 0; e_hi = 0; e_zero = 0; e_ovf = 0; e_ill = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < W + 2; i++) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1;
      end
      chk("abort_no_done", seen, 0);
    end

    // start together with reset: reset wins
    reset = 1'b1; start = 1'b1; alu_ctrl = ALU_MULT;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_done", done, 0);

    // random ops
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
      else c = legal[$urandom_range(0, 7)];
      run_op($sformatf("rnd%0d", i), c, W'($urandom), W'($urandom), -1);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        chk("rnd_idle_done", done, 0);
        chk("rnd_idle_hold", result, e_res[31:0]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
